ndata_compactor: RTL and testbench
==================================

// Module: ndata_compactor
// PURPOSE
//  Packs a sparse ndata stream (any keep pattern per beat) into dense beats:
//  kept elements move to the lowest lanes in arrival order, and beats are
//  fully populated except the final beat of each packet. Sits directly
//  upstream of the typed NData->AXI converter, which requires contiguous keep
//  (lanes 0..k-1). Packet boundaries (last) are preserved exactly.
// PARAMETERS
//  NUM_ELEMENTS  8   lanes per beat, >= 2
//  DATA_WIDTH    64  bits per element lane
// PORTS
//  clk        in   1                        clock
//  rst_n      in   1                        reset, synchronous, active-low
//  in.data    in   NUM_ELEMENTS*DATA_WIDTH  input lanes (ndata_i.s)
//  in.keep    in   NUM_ELEMENTS             per-lane valid mask, any pattern
//  in.last    in   1                        final beat of packet
//  in.valid   in   1                        input beat valid
//  in.ready   out  1                        input beat accepted when valid&ready
//  out.data   out  NUM_ELEMENTS*DATA_WIDTH  packed lanes (ndata_i.m)
//  out.keep   out  NUM_ELEMENTS             contiguous mask, lanes 0..cnt-1
//  out.last   out  1                        final beat of packet
//  out.valid  out  1                        output beat valid (registered)
//  out.ready  in   1                        downstream ready
// BEHAVIOUR
//  - Reset: out.valid=0, out.keep=0, out.last=0, residue cnt=0, state=RUN.
//  - Residue buffer: up to NUM_ELEMENTS-1 elements, count cnt in
//    $clog2(NUM_ELEMENTS) bits. k = popcount(in.keep); total = cnt+k, width
//    $clog2(2*NUM_ELEMENTS). Input kept lanes enter in ascending index order
//    after the residue.
//  - Output register: out.* change only when !out.valid || out.ready
//    (slot free). out.valid is held with stable data/keep/last until accepted.
//  - in.ready = (state==RUN) && slot free. Combinational, no in.valid dependence.
//  - On accept in RUN, with outputs loaded the next cycle (latency 1):
//    * !last, total<N:  nothing emitted; cnt=total.
//    * !last, total>=N: emit full beat (first N elements), keep all ones,
//      last=0; residue = remaining total-N elements; cnt=total-N.
//    * last, total<=N:  emit beat of total elements, last=1, cnt=0. total==0
//      emits keep=0, last=1, so empty-tail packets still terminate.
//    * last, total>N:   emit full beat (last=0), store total-N residue,
//      go to FLUSH.
//  - FLUSH: in.ready=0. When slot free, emit residue (cnt elements), last=1;
//    cnt=0; back to RUN. Takes exactly one extra output beat.
//  - Unused out.data lanes (keep=0) are don't-care; the bench checks only
//    kept lanes.
//  - Full throughput: one input beat per cycle when out.ready=1, except the
//    single FLUSH bubble on overflow-last.
//  - Reset mid-operation (any state): next cycle outputs at reset values and
//    residue is discarded; no partial beat is emitted afterwards.
// TESTING  (N=4, elements named by value)
//  1 keep=0101 {_,B,_,A}, then keep=1010 {D,_,C,_}, !last -> one beat
//    data {D,C,B,A}, keep=1111, last=0, 1 cycle after 2nd accept.
//  2 cnt=3 {C,B,A}, then keep=1111 {G,F,E,D} last -> beat {D,C,B,A} last=0,
//    in.ready=0 for one cycle, then beat {G,F,E} keep=0111 last=1.
//  3 cnt=0, keep=0000 last -> single beat keep=0000 last=1.
//  4 out.ready=0 for 5 cycles while out.valid=1 -> in.ready=0, out.* stable;
//    after release, no element lost or duplicated.
//  5 rst_n=0 for one cycle while in FLUSH -> out.valid=0 next cycle, cnt=0;
//    next packet {X} last emits keep=0001 only.
//  6 1000 random beats, random keep/last/valid/ready -> output order and
//    boundaries match the scoreboard; no beat except last has keep != 1111.

Source files
------------

// File: rtl/ndata_compactor.sv
// Packs a sparse ndata stream into dense beats: kept lanes move to the lowest
// lanes in arrival order, every beat is full except the final beat of a packet.
module ndata_compactor #(
    parameter int NUM_ELEMENTS = 8,
    parameter int DATA_WIDTH   = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_ELEMENTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_ELEMENTS-1:0]            in_keep,
    input  logic                               in_last,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [NUM_ELEMENTS*DATA_WIDTH-1:0] out_data,
    output logic [NUM_ELEMENTS-1:0]            out_keep,
    output logic                               out_last,
    output logic                               out_valid,
    input  logic                               out_ready
);
    localparam int N  = NUM_ELEMENTS;
    localparam int CW = $clog2(N);
    localparam int TW = $clog2(2 * N);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [0:0]            state_reg;
    logic [CW-1:0]         cnt_reg;
    logic [DATA_WIDTH-1:0] res_reg      [N];
    logic [DATA_WIDTH-1:0] out_lane_reg [N];
    logic [N-1:0]          out_keep_reg;
    logic                  out_last_reg;
    logic                  out_valid_reg;

    logic [DATA_WIDTH-1:0] in_lane [N];
    logic [DATA_WIDTH-1:0] merged  [2*N];
    logic [TW-1:0]         pos     [N];
    logic [TW-1:0]         total;
    logic                  slot_free;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lanes
            assign in_lane[gi]                          = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = out_lane_reg[gi];
        end
    endgenerate

    assign slot_free = !out_valid_reg || out_ready;
    assign in_ready  = (state_reg == RUN) && slot_free;
    assign out_keep  = out_keep_reg;
    assign out_last  = out_last_reg;
    assign out_valid = out_valid_reg;

    // Destination slot of each input lane: after the residue, then after
    // every lower-indexed kept lane.
    always_comb begin
        logic [TW-1:0] acc;
        acc = TW'(cnt_reg);
        for (int i = 0; i < N; i++) begin
            pos[i] = acc;
            acc    = acc + TW'(in_keep[i]);
        end
        total = acc;
    end

    // Residue followed by the compacted input, 2N slots wide.
    always_comb begin
        for (int j = 0; j < 2 * N; j++) begin
            merged[j] = '0;
        end
        for (int j = 0; j < N; j++) begin
            if (TW'(j) < TW'(cnt_reg)) begin
                merged[j] = res_reg[j];
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < 2 * N; j++) begin
                if (in_keep[i] && (pos[i] == TW'(j))) begin
                    merged[j] = in_lane[i];
                end
            end
        end
    end

    function automatic logic [N-1:0] low_mask(input logic [TW-1:0] n);
        logic [N-1:0] m;
        for (int j = 0; j < N; j++) begin
            m[j] = (TW'(j) < n);
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            cnt_reg       <= '0;
            out_keep_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else if (slot_free) begin
            out_valid_reg <= 1'b0;
            if (state_reg == FLUSH) begin
                for (int j = 0; j < N; j++) begin
                    out_lane_reg[j] <= res_reg[j];
                end
                out_keep_reg  <= low_mask(TW'(cnt_reg));
                out_last_reg  <= 1'b1;
                out_valid_reg <= 1'b1;
                cnt_reg       <= '0;
                state_reg     <= RUN;
            end else if (in_valid) begin
                if (in_last && (total <= TW'(N))) begin
                    for (int j = 0; j < N; j++) begin
                        out_lane_reg[j] <= merged[j];
                    end
                    out_keep_reg  <= low_mask(total);
                    out_last_reg  <= 1'b1;
                    out_valid_reg <= 1'b1;
                    cnt_reg       <= '0;
                end else if (total >= TW'(N)) begin
                    // A last beat that overflows leaves a residue for FLUSH.
                    for (int j = 0; j < N; j++) begin
                        out_lane_reg[j] <= merged[j];
                        res_reg[j]      <= merged[j+N];
                    end
                    out_keep_reg  <= '1;
                    out_last_reg  <= 1'b0;
                    out_valid_reg <= 1'b1;
                    cnt_reg       <= CW'(total - TW'(N));
                    if (in_last) begin
                        state_reg <= FLUSH;
                    end
                end else begin
                    for (int j = 0; j < N; j++) begin
                        res_reg[j] <= merged[j];
                    end
                    cnt_reg <= CW'(total);
                end
            end
        end
    end
endmodule

// File: tb/tb_ndata_compactor.sv
// Bench for ndata_compactor (N=4, 16-bit lanes): directed table, corner
// sequences and a random run, all checked against a scoreboard model.
module tb_ndata_compactor;
    localparam int N  = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [63:0]   in_data = '0;
    logic [N-1:0]  in_keep = '0;
    logic          in_last = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   out_data;
    logic [N-1:0]  out_keep;
    logic          out_last;
    logic          out_valid;
    logic          out_ready = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;
    bit rand_mode = 1'b0;

    typedef struct {
        logic [63:0]  data;
        logic [N-1:0] keep;
        logic         last;
    } beat_t;

    typedef struct {
        logic [N-1:0] keep;
        logic [63:0]  data;
        logic [N-1:0] exp_keep;
        logic [63:0]  exp_data;
    } vec_t;

    beat_t       exp_q[$];
    logic [DW-1:0] model_q[$];
    vec_t        vecs[6];

    ndata_compactor #(.NUM_ELEMENTS(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] kept(input logic [63:0] d, input logic [N-1:0] k);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (k[i]) r[i*DW +: DW] = d[i*DW +: DW];
        end
        return r;
    endfunction

    task automatic push_full();
        beat_t b;
        b.data = '0;
        for (int i = 0; i < N; i++) b.data[i*DW +: DW] = model_q.pop_front();
        b.keep = '1;
        b.last = 1'b0;
        exp_q.push_back(b);
    endtask

    task automatic push_tail();
        beat_t b;
        int n;
        b.data = '0;
        b.keep = '0;
        b.last = 1'b1;
        n = model_q.size();
        for (int i = 0; i < n; i++) begin
            b.data[i*DW +: DW] = model_q.pop_front();
            b.keep[i] = 1'b1;
        end
        exp_q.push_back(b);
    endtask

    task automatic model_accept();
        for (int i = 0; i < N; i++) begin
            if (in_keep[i]) model_q.push_back(in_data[i*DW +: DW]);
        end
        if (!in_last) begin
            if (model_q.size() >= N) push_full();
        end else begin
            while (model_q.size() > N) push_full();
            push_tail();
        end
    endtask

    // Monitor: samples the handshakes that complete at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_q.delete();
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                $display("beat keep=%b last=%b data=%h", out_keep, out_last, out_data);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got beat keep=%b last=%b, required none", out_keep, out_last);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("sb_keep", 64'(out_keep), 64'(e.keep));
                    check("sb_last", 64'(out_last), 64'(e.last));
                    check("sb_data", kept(out_data, e.keep), kept(e.data, e.keep));
                end
                if (!out_last) check("sb_full_keep", 64'(out_keep), 64'hF);
            end
            if (in_valid && in_ready) model_accept();
        end
    end

    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            out_ready = ($urandom_range(0, 9) < 7);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] k, input logic [63:0] d, input logic l);
        bit acc;
        int budget;
        in_keep  = k;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        acc      = 1'b0;
        budget   = 0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            budget++;
            if (!acc && budget > 300) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: got no accept in %0d cycles, required accept", budget);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #3000000;
        n_fail++;
        $display("FAIL watchdog: got simulation time limit, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int drain;
        vecs[0] = '{4'b1111, 64'h0004_0003_0002_0001, 4'b1111, 64'h0004_0003_0002_0001};
        vecs[1] = '{4'b0101, 64'hDEAD_000B_DEAD_000A, 4'b0011, 64'h0000_0000_000B_000A};
        vecs[2] = '{4'b1000, 64'h000D_BEEF_BEEF_BEEF, 4'b0001, 64'h0000_0000_0000_000D};
        vecs[3] = '{4'b0110, 64'hFFFF_000C_000B_FFFF, 4'b0011, 64'h0000_0000_000C_000B};
        vecs[4] = '{4'b0000, 64'h1111_2222_3333_4444, 4'b0000, 64'h0000_0000_0000_0000};
        vecs[5] = '{4'b1011, 64'h000D_EEEE_000B_000A, 4'b0111, 64'h0000_000D_000B_000A};

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_keep", 64'(out_keep), 64'h0);
        check("rst_last", 64'(out_last), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        rst_n = 1'b1;
        tick();

        // Single-beat packets from an empty residue
        for (int v = 0; v < 6; v++) begin
            send(vecs[v].keep, vecs[v].data, 1'b1);
            check("tv_valid", 64'(out_valid), 64'h1);
            check("tv_keep", 64'(out_keep), 64'(vecs[v].exp_keep));
            check("tv_last", 64'(out_last), 64'h1);
            check("tv_data", kept(out_data, vecs[v].exp_keep), vecs[v].exp_data);
            tick();
        end

        // Two sparse beats merge into one full beat
        send(4'b0101, 64'h5555_000B_5555_000A, 1'b0);
        check("s1_idle", 64'(out_valid), 64'h0);
        send(4'b1010, 64'h000D_9999_000C_9999, 1'b0);
        check("s1_valid", 64'(out_valid), 64'h1);
        check("s1_keep", 64'(out_keep), 64'hF);
        check("s1_last", 64'(out_last), 64'h0);
        check("s1_data", out_data, 64'h000D_000C_000B_000A);
        send(4'b0000, 64'h0, 1'b1);
        tick();

        // Overflowing last beat needs one FLUSH beat
        send(4'b0111, 64'h7777_000C_000B_000A, 1'b0);
        send(4'b1111, 64'h0007_0006_0005_0004, 1'b1);
        check("s2_keep0", 64'(out_keep), 64'hF);
        check("s2_last0", 64'(out_last), 64'h0);
        check("s2_data0", out_data, 64'h0004_000C_000B_000A);
        check("s2_in_ready_flush", 64'(in_ready), 64'h0);
        tick();
        check("s2_valid1", 64'(out_valid), 64'h1);
        check("s2_keep1", 64'(out_keep), 64'h7);
        check("s2_last1", 64'(out_last), 64'h1);
        check("s2_data1", kept(out_data, 4'b0111), 64'h0000_0007_0006_0005);
        check("s2_in_ready_run", 64'(in_ready), 64'h1);
        tick();

        // Downstream stall: output held, input blocked
        out_ready = 1'b0;
        send(4'b1111, 64'h0024_0023_0022_0021, 1'b1);
        in_keep  = 4'b0011;
        in_data  = 64'h0000_0000_0026_0025;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("s4_in_ready", 64'(in_ready), 64'h0);
            check("s4_valid", 64'(out_valid), 64'h1);
            check("s4_data", out_data, 64'h0024_0023_0022_0021);
            check("s4_keep", 64'(out_keep), 64'hF);
            check("s4_last", 64'(out_last), 64'h1);
        end
        out_ready = 1'b1;
        send(4'b0011, 64'h0000_0000_0026_0025, 1'b1);
        tick();
        tick();

        // Reset while in FLUSH discards the residue
        send(4'b0111, 64'h0000_003C_003B_003A, 1'b0);
        send(4'b1111, 64'h0037_0036_0035_0034, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("s5_valid", 64'(out_valid), 64'h0);
        check("s5_keep", 64'(out_keep), 64'h0);
        check("s5_last", 64'(out_last), 64'h0);
        send(4'b0100, 64'h0000_0058_0000_0000, 1'b1);
        check("s5_keep_x", 64'(out_keep), 64'h1);
        check("s5_last_x", 64'(out_last), 64'h1);
        check("s5_data_x", kept(out_data, 4'b0001), 64'h0000_0000_0000_0058);
        tick();
        check("s5_no_residue", 64'(out_valid), 64'h0);

        // Random traffic with random back-pressure
        rand_mode = 1'b1;
        for (int b = 0; b < 1000; b++) begin
            while ($urandom_range(0, 9) < 3) tick();
            send(4'($urandom), {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
        end
        send(4'b0000, 64'h0, 1'b1);
        rand_mode = 1'b0;
        tick();
        out_ready = 1'b1;
        drain = 0;
        while ((exp_q.size() != 0 || out_valid) && drain < 50) begin
            tick();
            drain++;
        end
        tick();
        check("drain_empty", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
